// File: rtl/packet_fifo_writer.sv
// packet_fifo_writer: write-side controller for the sample FIFO.
// Deserializes an MSB-first bit stream, hunts for a header byte and writes
// the following payload bytes into the FIFO, one single-cycle strobe per byte.
// A payload byte that meets full=1 is dropped and recorded in a sticky flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// HUNT    | waiting for a completed byte equal to HEADER_A or HEADER_B
// PAYLOAD | writing PAYLOAD_BYTES bytes into the FIFO, then back to HUNT
module packet_fifo_writer #(
  parameter logic [7:0] HEADER_A      = 8'hA5,
  parameter logic [7:0] HEADER_B      = 8'hC3,
  parameter int         PAYLOAD_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_data,
  input  logic       data_ena,
  input  logic       full,
  output logic       wr,
  output logic [7:0] wr_data,
  output logic       pkt_done,
  output logic       overflow
);

  localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t      state;
  logic [6:0]  shift_reg_lo;
  logic        shift_reg_msb;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_idx;
  logic        byte_done;
  logic [7:0]  byte_val;

  // The byte completes on the edge that takes its 8th bit, so the value is
  // formed from the seven stored bits plus the bit arriving now.
  assign byte_done = data_ena && (bit_cnt == 3'd7);
  assign byte_val  = {shift_reg_lo, serial_data};

  // Deserializer: shift in valid bits, drop a partial byte when data_ena gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg_msb <= 1'b0;
      shift_reg_lo  <= 7'd0;
      bit_cnt       <= 3'd0;
    end else if (data_ena) begin
      shift_reg_msb <= shift_reg_lo[6];
      shift_reg_lo  <= {shift_reg_lo[5:0], serial_data};
      bit_cnt       <= bit_cnt + 3'd1;
    end else if (bit_cnt != 3'd0) begin
      bit_cnt <= 3'd0;
    end
  end

  // Framing FSM with registered write strobe, data, packet-done and overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HUNT;
      byte_idx <= 4'd0;
      wr       <= 1'b0;
      wr_data  <= 8'h00;
      pkt_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr       <= 1'b0;
      pkt_done <= 1'b0;
      if (byte_done) begin
        case (state)
          HUNT: begin
            if (byte_val == HEADER_A || byte_val == HEADER_B) begin
              state    <= PAYLOAD;
              byte_idx <= 4'd0;
            end
          end
          PAYLOAD: begin
            if (!full) begin
              wr      <= 1'b1;
              wr_data <= byte_val;
            end else begin
              overflow <= 1'b1;
            end
            byte_idx <= byte_idx + 4'd1;
            if (byte_idx == LAST_IDX) begin
              pkt_done <= 1'b1;
              state    <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_fifo_writer.sv
// Directed testbench for packet_fifo_writer.
module tb_packet_fifo_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_data = 1'b0;
  logic       data_ena = 1'b0;
  logic       full = 1'b0;
  logic       wr;
  logic [7:0] wr_data;
  logic       pkt_done;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic       ovf_exp = 1'b0;
  logic [7:0] last_wd = 8'h00;

  packet_fifo_writer #(
    .HEADER_A(8'hA5),
    .HEADER_B(8'hC3),
    .PAYLOAD_BYTES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .serial_data(serial_data),
    .data_ena(data_ena),
    .full(full),
    .wr(wr),
    .wr_data(wr_data),
    .pkt_done(pkt_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      data_ena = i[0];
      serial_data = 1'b1;
      full = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_wr", 32'(wr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'h00);
      chk("rst_pkt_done", 32'(pkt_done), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    data_ena = 1'b0;
    ovf_exp = 1'b0;
    last_wd = 8'h00;
  endtask

  // Sends one byte MSB first; checks the strobe exactly one cycle after the
  // 8th bit and quiet outputs on every other cycle, then idles gap cycles.
  task automatic send_byte(input logic [7:0] b, input bit exp_wr, input bit exp_done,
                           input bit full_last, input int gap);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      data_ena = 1'b1;
      serial_data = b[i];
      full = (i == 0) ? full_last : 1'b0;
      @(posedge clk);
      #1;
      if (i != 0) begin
        chk("mid_wr", 32'(wr), 32'd0);
        chk("mid_pkt_done", 32'(pkt_done), 32'd0);
      end
    end
    if (exp_wr) last_wd = b;
    if (full_last) ovf_exp = 1'b1;
    chk("byte_wr", 32'(wr), 32'(exp_wr));
    chk("byte_wr_data", 32'(wr_data), 32'(last_wd));
    chk("byte_pkt_done", 32'(pkt_done), 32'(exp_done));
    chk("byte_overflow", 32'(overflow), 32'(ovf_exp));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      data_ena = 1'b0;
      full = 1'b0;
      @(posedge clk);
      #1;
      chk("gap_wr", 32'(wr), 32'd0);
      chk("gap_pkt_done", 32'(pkt_done), 32'd0);
    end
  endtask

  // Sends n leading bits of a byte and then drops data_ena for one cycle.
  task automatic send_partial(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      data_ena = 1'b1;
      serial_data = b[i];
      full = 1'b0;
      @(posedge clk);
      #1;
      chk("part_wr", 32'(wr), 32'd0);
    end
    @(negedge clk);
    data_ena = 1'b0;
    @(posedge clk);
    #1;
    chk("part_gap_wr", 32'(wr), 32'd0);
  endtask

  initial begin
    // Reset, then a basic packet with continuous data_ena.
    do_reset(3);
    send_byte(8'hA5, 0, 0, 0, 0);
    send_byte(8'h11, 1, 0, 0, 0);
    send_byte(8'h22, 1, 0, 0, 0);
    send_byte(8'h33, 1, 0, 0, 0);
    send_byte(8'h44, 1, 1, 0, 1);

    // Hunt: non-headers ignored, C3 is a header, A5 is then payload data.
    do_reset(1);
    send_byte(8'h00, 0, 0, 0, 0);
    send_byte(8'hFF, 0, 0, 0, 0);
    send_byte(8'hC3, 0, 0, 0, 0);
    send_byte(8'hA5, 1, 0, 0, 0);
    send_byte(8'h01, 1, 0, 0, 0);
    send_byte(8'h02, 1, 0, 0, 0);
    send_byte(8'h03, 1, 1, 0, 1);
    // Header on the very next byte after packet end is accepted.
    send_byte(8'hA5, 0, 0, 0, 0);
    send_byte(8'h5A, 1, 0, 0, 0);
    send_byte(8'h6B, 1, 0, 0, 0);
    send_byte(8'h7C, 1, 0, 0, 0);
    send_byte(8'h8D, 1, 1, 0, 1);

    // Full on the second payload byte: dropped, overflow sticky, done still pulses.
    do_reset(1);
    send_byte(8'hA5, 0, 0, 0, 0);
    send_byte(8'h10, 1, 0, 0, 0);
    send_byte(8'h20, 0, 0, 1, 0);
    send_byte(8'h30, 1, 0, 0, 0);
    send_byte(8'h40, 1, 1, 0, 2);
    send_byte(8'h99, 0, 0, 0, 1);
    // Dropped last byte: pkt_done pulses with wr=0.
    send_byte(8'hC3, 0, 0, 0, 0);
    send_byte(8'h01, 1, 0, 0, 0);
    send_byte(8'h02, 1, 0, 0, 0);
    send_byte(8'h03, 1, 0, 0, 0);
    send_byte(8'h04, 0, 1, 1, 1);

    // Framing: partial byte discarded, next byte counted once.
    do_reset(1);
    send_byte(8'hA5, 0, 0, 0, 0);
    send_byte(8'h11, 1, 0, 0, 0);
    send_partial(8'hFF, 5);
    send_byte(8'h55, 1, 0, 0, 0);
    send_byte(8'h66, 1, 0, 0, 0);
    send_byte(8'h77, 1, 1, 0, 1);

    // Reset mid-packet aborts; a fresh header is required.
    do_reset(1);
    send_byte(8'hA5, 0, 0, 0, 0);
    send_byte(8'h01, 1, 0, 0, 0);
    do_reset(2);
    send_byte(8'h02, 0, 0, 0, 0);
    send_byte(8'h03, 0, 0, 0, 0);
    send_byte(8'hC3, 0, 0, 0, 0);
    send_byte(8'h04, 1, 0, 0, 0);
    send_byte(8'h05, 1, 0, 0, 0);
    send_byte(8'h06, 1, 0, 0, 0);
    send_byte(8'h07, 1, 1, 0, 1);

    // Gapped data_ena: random idle cycles between bytes (a gap inside a byte
    // would discard it).
    do_reset(1);
    send_byte(8'hA5, 0, 0, 0, $urandom_range(3, 0));
    send_byte(8'hAA, 1, 0, 0, $urandom_range(3, 0));
    send_byte(8'hBB, 1, 0, 0, $urandom_range(3, 0));
    send_byte(8'hCC, 1, 0, 0, $urandom_range(3, 0));
    send_byte(8'hDD, 1, 1, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
